// File: rtl/smart_light_pkg.sv
// -----------------------------------------------------------------------------
// smart_light_pkg
// Shared definitions for the smart-house lighting path.
//   - light_state_t : 3-bit encoding of the light sequencer FSM state
//   - DEFAULT_*     : default hold / warn durations and timer width, also used
//                     by the house-level top when it instantiates the sequencer
// -----------------------------------------------------------------------------
package smart_light_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LIT      = 3'd1,
        ST_HOLD     = 3'd2,
        ST_WARN     = 3'd3,
        ST_OVERRIDE = 3'd4
    } light_state_t;

    localparam int DEFAULT_HOLD_SECS = 30;
    localparam int DEFAULT_WARN_SECS = 5;
    localparam int DEFAULT_TIMER_W   = 8;

endpackage : smart_light_pkg

// File: rtl/sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchronizer for a single asynchronous level input.
// Ports:
//   i_clk : destination clock
//   i_rst : asynchronous, active-high reset (both flops clear to 0)
//   i_d   : asynchronous input level
//   o_q   : synchronized level, two clk edges behind i_d
// -----------------------------------------------------------------------------
module sync2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync2

// File: rtl/light_sequencer.sv
// -----------------------------------------------------------------------------
// light_sequencer
// Occupancy-driven room light controller. Sequences the lamp through
// IDLE -> LIT -> HOLD -> (WARN) -> IDLE on synchronized movement & dark,
// with manual on/off override (off has priority over on, on over auto).
//
// Parameters:
//   HOLD_SECS : ticks the light stays on after occupancy ends (1..2^TIMER_W-1)
//   WARN_SECS : ticks of warning blink before off            (1..2^TIMER_W-1)
//   TIMER_W   : countdown timer width
// Ports:
//   clk        : system clock
//   rst        : asynchronous, active-high reset
//   movement   : raw movement sensor (asynchronous)
//   dark       : raw dark sensor (asynchronous)
//   manual_on  : single-cycle manual on request
//   manual_off : single-cycle manual off request
//   tick       : single-cycle 1 Hz enable
//   light      : registered lamp drive
//   state      : current FSM state (light_state_t encoding)
//   timer      : remaining ticks in HOLD/WARN, 0 otherwise
// Build option:
//   WARN_BLINK_EN : when defined, HOLD expiry enters WARN (blinking light for
//                   WARN_SECS ticks); when undefined, HOLD expiry goes straight
//                   to IDLE and WARN is never entered.
// -----------------------------------------------------------------------------
module light_sequencer
    import smart_light_pkg::*;
#(
    parameter int HOLD_SECS = DEFAULT_HOLD_SECS,
    parameter int WARN_SECS = DEFAULT_WARN_SECS,
    parameter int TIMER_W   = DEFAULT_TIMER_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               movement,
    input  logic               dark,
    input  logic               manual_on,
    input  logic               manual_off,
    input  logic               tick,
    output logic               light,
    output logic [2:0]         state,
    output logic [TIMER_W-1:0] timer
);

    // Reject out-of-range durations at elaboration; a zero load would never
    // see the timer==1 expiry condition.
    if (HOLD_SECS < 1 || HOLD_SECS > (2 ** TIMER_W) - 1 ||
        WARN_SECS < 1 || WARN_SECS > (2 ** TIMER_W) - 1) begin : g_param_check
        $error("light_sequencer: HOLD_SECS/WARN_SECS outside 1..2^TIMER_W-1");
    end

    localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(HOLD_SECS);
    localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);
`ifdef WARN_BLINK_EN
    localparam logic [TIMER_W-1:0] WARN_LOAD = TIMER_W'(WARN_SECS);
`endif

    // ---------------------------------------------------------------------
    // Sensor synchronization: bit 0 = movement, bit 1 = dark
    // ---------------------------------------------------------------------
    logic [1:0] w_raw;
    logic [1:0] w_sync;
    logic       w_auto_req;

    assign w_raw = {dark, movement};

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_sync
        sync2 u_sync (
            .i_clk (clk),
            .i_rst (rst),
            .i_d   (w_raw[gi]),
            .o_q   (w_sync[gi])
        );
    end

    assign w_auto_req = w_sync[0] & w_sync[1];

    // ---------------------------------------------------------------------
    // FSM with registered light and countdown timer
    // ---------------------------------------------------------------------
    light_state_t       r_state;
    logic               r_light;
    logic [TIMER_W-1:0] r_timer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_light <= 1'b0;
            r_timer <= '0;
        end else if (manual_off) begin
            r_state <= ST_IDLE;
            r_light <= 1'b0;
            r_timer <= '0;
        end else if (manual_on && (r_state != ST_OVERRIDE)) begin
            r_state <= ST_OVERRIDE;
            r_light <= 1'b1;
            r_timer <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_auto_req) begin
                        r_state <= ST_LIT;
                        r_light <= 1'b1;
                    end
                end
                ST_LIT: begin
                    // A tick in the entry cycle is deliberately not counted.
                    if (!w_auto_req) begin
                        r_state <= ST_HOLD;
                        r_timer <= HOLD_LOAD;
                    end
                end
                ST_HOLD: begin
                    // Occupancy returning beats a simultaneous expiry.
                    if (w_auto_req) begin
                        r_state <= ST_LIT;
                        r_light <= 1'b1;
                        r_timer <= '0;
                    end else if (tick) begin
                        if (r_timer == TIMER_ONE) begin
`ifdef WARN_BLINK_EN
                            r_state <= ST_WARN;
                            r_light <= 1'b1;
                            r_timer <= WARN_LOAD;
`else
                            r_state <= ST_IDLE;
                            r_light <= 1'b0;
                            r_timer <= '0;
`endif
                        end else if (r_timer != '0) begin
                            r_timer <= r_timer - TIMER_ONE;
                        end
                    end
                end
`ifdef WARN_BLINK_EN
                ST_WARN: begin
                    if (w_auto_req) begin
                        r_state <= ST_LIT;
                        r_light <= 1'b1;
                        r_timer <= '0;
                    end else if (tick) begin
                        if (r_timer == TIMER_ONE) begin
                            r_state <= ST_IDLE;
                            r_light <= 1'b0;
                            r_timer <= '0;
                        end else begin
                            if (r_timer != '0) begin
                                r_timer <= r_timer - TIMER_ONE;
                            end
                            r_light <= ~r_light;
                        end
                    end
                end
`endif
                ST_OVERRIDE: begin
                    // Only manual_off (handled above) leaves OVERRIDE.
                    r_light <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_light <= 1'b0;
                    r_timer <= '0;
                end
            endcase
        end
    end

    assign light = r_light;
    assign state = r_state;
    assign timer = r_timer;

endmodule : light_sequencer

// File: tb/tb_light_sequencer.sv
// -----------------------------------------------------------------------------
// tb_light_sequencer
// Self-checking bench for light_sequencer (HOLD_SECS=3, WARN_SECS=2).
// Each scenario task queues expected {state, light, timer} as it drives a
// cycle of stimulus, then pops and compares after the clock edge.
// Expectations follow the WARN_BLINK_EN build option.
// -----------------------------------------------------------------------------
module tb_light_sequencer;

    localparam int HOLD = 3;
    localparam int WARN = 2;
    localparam int TW   = 8;
`ifdef WARN_BLINK_EN
    localparam bit WARN_ON = 1'b1;
`else
    localparam bit WARN_ON = 1'b0;
`endif

    logic          clk        = 1'b0;
    logic          rst        = 1'b0;
    logic          movement   = 1'b0;
    logic          dark       = 1'b0;
    logic          manual_on  = 1'b0;
    logic          manual_off = 1'b0;
    logic          tick       = 1'b0;
    logic          light;
    logic [2:0]    state;
    logic [TW-1:0] timer;

    always #5 clk = ~clk;

    light_sequencer #(
        .HOLD_SECS (HOLD),
        .WARN_SECS (WARN),
        .TIMER_W   (TW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .movement   (movement),
        .dark       (dark),
        .manual_on  (manual_on),
        .manual_off (manual_off),
        .tick       (tick),
        .light      (light),
        .state      (state),
        .timer      (timer)
    );

    typedef struct {
        string         name;
        logic          mv, dk, on, off, tk;
        logic [2:0]    st;
        logic          lt;
        logic [TW-1:0] tm;
    } step_t;

    typedef struct {
        string         name;
        logic [2:0]    st;
        logic          lt;
        logic [TW-1:0] tm;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic step_t mk(input string name, input logic mv, input logic dk,
                                 input logic on, input logic off, input logic tk,
                                 input logic [2:0] st, input logic lt, input logic [TW-1:0] tm);
        step_t s;
        s.name = name; s.mv = mv; s.dk = dk; s.on = on; s.off = off; s.tk = tk;
        s.st = st; s.lt = lt; s.tm = tm;
        return s;
    endfunction

    // Apply one cycle of stimulus and queue what the DUT must show after the edge.
    task automatic drive(input step_t s);
        exp_t e;
        movement   = s.mv;
        dark       = s.dk;
        manual_on  = s.on;
        manual_off = s.off;
        tick       = s.tk;
        e.name = s.name; e.st = s.st; e.lt = s.lt; e.tm = s.tm;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        #2 rst = 1'b1;
        exp_q.push_back('{"reset_asserted", 3'd0, 1'b0, 8'd0});
        #1;
        e = exp_q.pop_front();
        total++;
        if ({state, light, timer} !== {e.st, e.lt, e.tm}) begin
            bad++;
            $display("FAIL %s: got state=%0d light=%0d timer=%0d, expected state=%0d light=%0d timer=%0d",
                     e.name, state, light, timer, e.st, e.lt, e.tm);
        end else $display("pass %s: state=%0d light=%0d timer=%0d", e.name, state, light, timer);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.push_back('{"reset_released", 3'd0, 1'b0, 8'd0});
        @(posedge clk); #1;
        e = exp_q.pop_front();
        total++;
        if ({state, light, timer} !== {e.st, e.lt, e.tm}) begin
            bad++;
            $display("FAIL %s: got state=%0d light=%0d timer=%0d, expected state=%0d light=%0d timer=%0d",
                     e.name, state, light, timer, e.st, e.lt, e.tm);
        end else $display("pass %s: state=%0d light=%0d timer=%0d", e.name, state, light, timer);
    endtask

    // Sensors to light: 2 sync flops + state register = 3 clk.
    task automatic test_auto_on();
        step_t q[$];
        exp_t  e;
        q.push_back(mk("auto_clk1", 1, 1, 0, 0, 0, 3'd0, 0, 0));
        q.push_back(mk("auto_clk2", 1, 1, 0, 0, 0, 3'd0, 0, 0));
        q.push_back(mk("auto_clk3", 1, 1, 0, 0, 0, 3'd1, 1, 0));
        foreach (q[i]) begin
            drive(q[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            total++;
            if ({state, light, timer} !== {e.st, e.lt, e.tm}) begin
                bad++;
                $display("FAIL %s: got state=%0d light=%0d timer=%0d, expected state=%0d light=%0d timer=%0d",
                         e.name, state, light, timer, e.st, e.lt, e.tm);
            end else $display("pass %s: state=%0d light=%0d timer=%0d", e.name, state, light, timer);
        end
    endtask

    // LIT -> HOLD (3 ticks) -> WARN (2 ticks, blink) -> IDLE; the tick on the
    // HOLD entry cycle must not count.
    task automatic test_hold_warn();
        step_t q[$];
        exp_t  e;
        q.push_back(mk("hw_mv_low1",   0, 1, 0, 0, 0, 3'd1, 1, 0));
        q.push_back(mk("hw_mv_low2",   0, 1, 0, 0, 0, 3'd1, 1, 0));
        q.push_back(mk("hw_hold_entry_tick", 0, 1, 0, 0, 1, 3'd2, 1, 3));
        q.push_back(mk("hw_hold_t2",   0, 1, 0, 0, 1, 3'd2, 1, 2));
        q.push_back(mk("hw_hold_notick", 0, 1, 0, 0, 0, 3'd2, 1, 2));
        q.push_back(mk("hw_hold_t1",   0, 1, 0, 0, 1, 3'd2, 1, 1));
        q.push_back(mk("hw_hold_expire", 0, 1, 0, 0, 1,
                       WARN_ON ? 3'd3 : 3'd0, WARN_ON ? 1'b1 : 1'b0, WARN_ON ? 8'd2 : 8'd0));
        q.push_back(mk("hw_warn_blink", 0, 1, 0, 0, 1,
                       WARN_ON ? 3'd3 : 3'd0, 1'b0, WARN_ON ? 8'd1 : 8'd0));
        q.push_back(mk("hw_warn_expire", 0, 1, 0, 0, 1, 3'd0, 0, 0));
        q.push_back(mk("hw_idle_stays", 0, 1, 0, 0, 0, 3'd0, 0, 0));
        foreach (q[i]) begin
            drive(q[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            total++;
            if ({state, light, timer} !== {e.st, e.lt, e.tm}) begin
                bad++;
                $display("FAIL %s: got state=%0d light=%0d timer=%0d, expected state=%0d light=%0d timer=%0d",
                         e.name, state, light, timer, e.st, e.lt, e.tm);
            end else $display("pass %s: state=%0d light=%0d timer=%0d", e.name, state, light, timer);
        end
    endtask

    // Synced occupancy returns on the same cycle as the expiring tick: LIT wins.
    task automatic test_hold_rescue();
        step_t q[$];
        exp_t  e;
        q.push_back(mk("rs_on1",   1, 1, 0, 0, 0, 3'd0, 0, 0));
        q.push_back(mk("rs_on2",   1, 1, 0, 0, 0, 3'd0, 0, 0));
        q.push_back(mk("rs_lit",   1, 1, 0, 0, 0, 3'd1, 1, 0));
        q.push_back(mk("rs_off1",  0, 1, 0, 0, 0, 3'd1, 1, 0));
        q.push_back(mk("rs_off2",  0, 1, 0, 0, 0, 3'd1, 1, 0));
        q.push_back(mk("rs_hold3", 0, 1, 0, 0, 0, 3'd2, 1, 3));
        q.push_back(mk("rs_hold2", 0, 1, 0, 0, 1, 3'd2, 1, 2));
        q.push_back(mk("rs_hold1", 0, 1, 0, 0, 1, 3'd2, 1, 1));
        q.push_back(mk("rs_mv_sync1", 1, 1, 0, 0, 0, 3'd2, 1, 1));
        q.push_back(mk("rs_mv_sync2", 1, 1, 0, 0, 0, 3'd2, 1, 1));
        q.push_back(mk("rs_tick_and_auto", 1, 1, 0, 0, 1, 3'd1, 1, 0));
        foreach (q[i]) begin
            drive(q[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            total++;
            if ({state, light, timer} !== {e.st, e.lt, e.tm}) begin
                bad++;
                $display("FAIL %s: got state=%0d light=%0d timer=%0d, expected state=%0d light=%0d timer=%0d",
                         e.name, state, light, timer, e.st, e.lt, e.tm);
            end else $display("pass %s: state=%0d light=%0d timer=%0d", e.name, state, light, timer);
        end
    endtask

    // manual_off beats a still-high auto_req; manual_on from IDLE in the dark=0
    // case enters OVERRIDE, which ignores ticks and sensors; on+off -> IDLE.
    task automatic test_override();
        step_t q[$];
        exp_t  e;
        q.push_back(mk("ov_off_from_lit", 0, 0, 0, 1, 0, 3'd0, 0, 0));
        q.push_back(mk("ov_off_vs_auto1", 0, 0, 0, 1, 0, 3'd0, 0, 0));
        q.push_back(mk("ov_off_vs_auto2", 0, 0, 0, 1, 0, 3'd0, 0, 0));
        q.push_back(mk("ov_idle_dark0",   0, 0, 0, 0, 0, 3'd0, 0, 0));
        q.push_back(mk("ov_manual_on",    0, 0, 1, 0, 0, 3'd4, 1, 0));
        for (int k = 0; k < 100; k++) begin
            // Sensors high for most of the run, dropped before the exit.
            q.push_back(mk($sformatf("ov_tick%0d", k), (k < 98), (k < 98), 0, 0, 1, 3'd4, 1, 0));
        end
        q.push_back(mk("ov_on_and_off",   0, 0, 1, 1, 0, 3'd0, 0, 0));
        q.push_back(mk("ov_idle_after",   0, 0, 0, 0, 1, 3'd0, 0, 0));
        q.push_back(mk("ov_idle_after2",  0, 0, 0, 0, 0, 3'd0, 0, 0));
        foreach (q[i]) begin
            drive(q[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            total++;
            if ({state, light, timer} !== {e.st, e.lt, e.tm}) begin
                bad++;
                $display("FAIL %s: got state=%0d light=%0d timer=%0d, expected state=%0d light=%0d timer=%0d",
                         e.name, state, light, timer, e.st, e.lt, e.tm);
            end else $display("pass %s: state=%0d light=%0d timer=%0d", e.name, state, light, timer);
        end
    endtask

    // Asynchronous reset in the last WARN tick (last HOLD tick without the
    // warn option) clears everything before any clock edge; no blink follows.
    task automatic test_reset_mid_warn();
        step_t q[$];
        exp_t  e;
        q.push_back(mk("rw_on1",   1, 1, 0, 0, 0, 3'd0, 0, 0));
        q.push_back(mk("rw_on2",   1, 1, 0, 0, 0, 3'd0, 0, 0));
        q.push_back(mk("rw_lit",   1, 1, 0, 0, 0, 3'd1, 1, 0));
        q.push_back(mk("rw_off1",  0, 1, 0, 0, 0, 3'd1, 1, 0));
        q.push_back(mk("rw_off2",  0, 1, 0, 0, 0, 3'd1, 1, 0));
        q.push_back(mk("rw_hold3", 0, 1, 0, 0, 0, 3'd2, 1, 3));
        q.push_back(mk("rw_hold2", 0, 1, 0, 0, 1, 3'd2, 1, 2));
        q.push_back(mk("rw_hold1", 0, 1, 0, 0, 1, 3'd2, 1, 1));
`ifdef WARN_BLINK_EN
        q.push_back(mk("rw_warn2", 0, 1, 0, 0, 1, 3'd3, 1, 2));
        q.push_back(mk("rw_warn1", 0, 1, 0, 0, 1, 3'd3, 0, 1));
`endif
        foreach (q[i]) begin
            drive(q[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            total++;
            if ({state, light, timer} !== {e.st, e.lt, e.tm}) begin
                bad++;
                $display("FAIL %s: got state=%0d light=%0d timer=%0d, expected state=%0d light=%0d timer=%0d",
                         e.name, state, light, timer, e.st, e.lt, e.tm);
            end else $display("pass %s: state=%0d light=%0d timer=%0d", e.name, state, light, timer);
        end
        tick = 1'b0;
        #2 rst = 1'b1;
        exp_q.push_back('{"rw_async_reset", 3'd0, 1'b0, 8'd0});
        #1;
        e = exp_q.pop_front();
        total++;
        if ({state, light, timer} !== {e.st, e.lt, e.tm}) begin
            bad++;
            $display("FAIL %s: got state=%0d light=%0d timer=%0d, expected state=%0d light=%0d timer=%0d",
                     e.name, state, light, timer, e.st, e.lt, e.tm);
        end else $display("pass %s: state=%0d light=%0d timer=%0d", e.name, state, light, timer);
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        for (int k = 0; k < 3; k++) begin
            q.push_back(mk($sformatf("rw_no_blink%0d", k), 0, 1, 0, 0, 1, 3'd0, 0, 0));
        end
        foreach (q[i]) begin
            drive(q[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            total++;
            if ({state, light, timer} !== {e.st, e.lt, e.tm}) begin
                bad++;
                $display("FAIL %s: got state=%0d light=%0d timer=%0d, expected state=%0d light=%0d timer=%0d",
                         e.name, state, light, timer, e.st, e.lt, e.tm);
            end else $display("pass %s: state=%0d light=%0d timer=%0d", e.name, state, light, timer);
        end
    endtask

    initial begin
        test_reset();
        test_auto_on();
        test_hold_warn();
        test_hold_rescue();
        test_override();
        test_reset_mid_warn();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_light_sequencer
